// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register driving instruction memory, plus the registered fetch/decode boundary.
// Optional build macro PC_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and set a sticky flag.
module fetch_pc_unit #(
  parameter int unsigned              ADDRESS_WIDTH     = 32,
  parameter int unsigned              INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [1:0]                   PCsrc,
  input  logic [ADDRESS_WIDTH-1:0]     ImmExt,
  input  logic [ADDRESS_WIDTH-1:0]     rs1_data,
  output logic [ADDRESS_WIDTH-1:0]     A,
  input  logic [INSTRUCTION_WIDTH-1:0] RD,
  output logic [INSTRUCTION_WIDTH-1:0] instr_d,
  output logic [ADDRESS_WIDTH-1:0]     pc_d,
  output logic [ADDRESS_WIDTH-1:0]     pc_plus4_d,
  output logic                         valid_d,
  output logic                         misalign
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(32'h0000_0013);

  state_e                         state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]       fpc_q, fpc_d;
  logic [INSTRUCTION_WIDTH-1:0]   dinstr_q, dinstr_d;
  logic [ADDRESS_WIDTH-1:0]       dpc_q, dpc_d;
  logic [ADDRESS_WIDTH-1:0]       dpc4_q, dpc4_d;
  logic                           dvalid_q, dvalid_d;
  logic                           misalign_q, misalign_d;

  logic [ADDRESS_WIDTH-1:0]       seq_pc, br_tgt, jalr_tgt, tgt;
  logic                           redirect;

  always_comb begin
    seq_pc   = fpc_q + ADDRESS_WIDTH'(4);
    br_tgt   = dpc_q + ImmExt;
    jalr_tgt = (rs1_data + ImmExt) & ~ADDRESS_WIDTH'(1);
    redirect = (PCsrc == 2'b01) || (PCsrc == 2'b10);
    tgt      = (PCsrc == 2'b01) ? br_tgt : jalr_tgt;
  end

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    dinstr_d   = dinstr_q;
    dpc_d      = dpc_q;
    dpc4_d     = dpc4_q;
    dvalid_d   = dvalid_q;
    misalign_d = misalign_q;

    if (state_q == HALT) begin
      dvalid_d = 1'b0;
    end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1]) begin
        // Trap leaves PC and the decode payload untouched; only valid drops.
        misalign_d = 1'b1;
        dvalid_d   = 1'b0;
        state_d    = HALT;
      end else begin
        fpc_d    = tgt;
        dinstr_d = RD;
        dpc_d    = fpc_q;
        dpc4_d   = seq_pc;
        dvalid_d = 1'b0;
      end
`else
      fpc_d    = tgt & ~ADDRESS_WIDTH'(3);
      dinstr_d = RD;
      dpc_d    = fpc_q;
      dpc4_d   = seq_pc;
      dvalid_d = 1'b0;
`endif
    end else if (!stall) begin
      fpc_d    = seq_pc;
      dinstr_d = RD;
      dpc_d    = fpc_q;
      dpc4_d   = seq_pc;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fpc_q      <= RESET_VECTOR;
      dinstr_q   <= NOP;
      dpc_q      <= '0;
      dpc4_q     <= '0;
      dvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      dinstr_q   <= dinstr_d;
      dpc_q      <= dpc_d;
      dpc4_q     <= dpc4_d;
      dvalid_q   <= dvalid_d;
      misalign_q <= misalign_d;
    end
  end

  assign A          = fpc_q;
  assign instr_d    = dinstr_q;
  assign pc_d       = dpc_q;
  assign pc_plus4_d = dpc4_q;
  assign valid_d    = dvalid_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

endmodule
